// File: rtl/cpu_io_driver.sv
// Host-side driver for the CPU's I/O ports.
// Bytes arrive on a valid/ready stream, wait in a small FIFO and are presented
// one at a time on in_port. ready_in is raised only after in_port has been
// stable long enough for the CPU's 2-flop input synchroniser. A monitor watches
// out_port and emits a one-cycle strobe whenever the CPU writes a new value.
module cpu_io_driver #(
  parameter int BUS_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BUS_WIDTH-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [BUS_WIDTH-1:0]          in_port,
  output logic                          ready_in,
  input  logic [BUS_WIDTH-1:0]          out_port,
  output logic [BUS_WIDTH-1:0]          m_data,
  output logic                          m_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES)
                           ? ((HOLD_CYCLES > 2) ? HOLD_CYCLES : 2)
                           : ((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ASSERT,
    S_GAP
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;

  logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 push;
  logic                 pop;
  logic [BUS_WIDTH-1:0] shadow;

  // A full FIFO refuses data even if a pop frees a slot in the same cycle.
  assign s_ready = (fifo_count < (PTR_W + 1)'(FIFO_DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = (state == S_IDLE) && (fifo_count != '0);
  assign busy    = (state != S_IDLE);

  // FIFO storage: data only, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Handshake FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: each phase runs a fixed number of cycles counted by cnt.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    unique case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (fifo_count != '0) begin
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        // Two cycles let the byte pass the CPU's input synchroniser.
        if (cnt == CNT_W'(1)) begin
          state_nxt = S_ASSERT;
          cnt_nxt   = '0;
        end
      end
      S_ASSERT: begin
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Registered CPU-facing outputs; ready_in trails the ASSERT phase by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_port  <= '0;
      ready_in <= 1'b0;
    end else begin
      if (pop) begin
        in_port <= mem[rd_ptr];
      end
      ready_in <= (state == S_ASSERT);
    end
  end

  // Output monitor: strobe whenever out_port differs from last cycle's value.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      shadow <= out_port;
      if (out_port != shadow) begin
        m_data  <= out_port;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_io_driver.sv
// Self-checking bench for cpu_io_driver: a timeline model of pop times and
// monitor strobes checked every cycle, plus directed literal checks.
module tb_cpu_io_driver;

  localparam int BW = 8;
  localparam int D  = 4;
  localparam int H  = 4;
  localparam int G  = 2;
  localparam int P  = 1 + 2 + H + G;

  logic          clk;
  logic          reset;
  logic [BW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] in_port;
  logic          ready_in;
  logic [BW-1:0] out_port;
  logic [BW-1:0] m_data;
  logic          m_valid;
  logic [2:0]    fifo_count;
  logic          busy;

  cpu_io_driver #(
    .BUS_WIDTH  (BW),
    .FIFO_DEPTH (D),
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .in_port   (in_port),
    .ready_in  (ready_in),
    .out_port  (out_port),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .fifo_count(fifo_count),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte pops at the first edge after it was pushed,
  // but no sooner than P edges after the previous pop. All outputs follow
  // from the distance to the last pop edge.
  logic [BW-1:0] mq[$];
  logic [BW-1:0] m_cur    = '0;
  logic [BW-1:0] m_shadow = '0;
  logic [BW-1:0] e_mdata  = '0;
  logic          e_mvalid = 1'b0;
  int            edge_no  = 0;
  int            last_pop = -1000;
  bit            armed    = 1'b0;

  initial begin
    int sz;
    forever begin
      @(posedge clk);
      edge_no++;
      if (reset) begin
        mq.delete();
        m_cur    = '0;
        m_shadow = '0;
        e_mdata  = '0;
        e_mvalid = 1'b0;
        last_pop = -1000;
        armed    = 1'b1;
      end else begin
        sz = mq.size();
        if (sz > 0 && (edge_no - last_pop) >= P) begin
          m_cur    = mq.pop_front();
          last_pop = edge_no;
        end
        if (s_valid && sz < D) mq.push_back(s_data);
        e_mvalid = (out_port != m_shadow);
        if (e_mvalid) e_mdata = out_port;
        m_shadow = out_port;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (armed) begin
        d = edge_no - last_pop;
        chk("in_port",    32'(in_port),    32'(m_cur));
        chk("ready_in",   32'(ready_in),   32'(d >= 3 && d < 3 + H));
        chk("busy",       32'(busy),       32'(d >= 0 && d <= P - 2));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("s_ready",    32'(s_ready),    32'(mq.size() < D));
        chk("m_valid",    32'(m_valid),    32'(e_mvalid));
        chk("m_data",     32'(m_data),     32'(e_mdata));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [BW-1:0] b);
    bit acc;
    int n;
    n       = 0;
    s_data  = b;
    s_valid = 1'b1;
    do begin
      acc = s_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 200);
    s_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_ready(input logic lvl);
    int n;
    n = 0;
    while (ready_in !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready_in", 32'(ready_in), 32'(lvl));
  endtask

  logic [BW-1:0] cpu_bytes [3];
  logic [BW-1:0] exp_res;

  initial begin
    s_valid  = 1'b0;
    s_data   = '0;
    out_port = '0;
    reset    = 1'b1;
    step(3);
    reset = 1'b0;
    step(10);

    // Idle after reset.
    chk("idle_in_port",    32'(in_port),    32'(0));
    chk("idle_ready_in",   32'(ready_in),   32'(0));
    chk("idle_m_valid",    32'(m_valid),    32'(0));
    chk("idle_s_ready",    32'(s_ready),    32'(1));
    chk("idle_fifo_count", 32'(fifo_count), 32'(0));
    chk("idle_busy",       32'(busy),       32'(0));

    // Single byte: pop one edge after push, ready_in high 4..7 edges after push.
    s_data  = 8'h5A;
    s_valid = 1'b1;
    step(1);
    s_valid = 1'b0;
    step(1);
    chk("single_in_port", 32'(in_port),    32'(8'h5A));
    chk("single_busy",    32'(busy),       32'(1));
    chk("single_count",   32'(fifo_count), 32'(0));
    step(2);
    chk("single_rdy_j3",  32'(ready_in),   32'(0));
    step(1);
    chk("single_rdy_j4",  32'(ready_in),   32'(1));
    step(3);
    chk("single_rdy_j7",  32'(ready_in),   32'(1));
    step(1);
    chk("single_rdy_j8",  32'(ready_in),   32'(0));
    chk("single_busy_j8", 32'(busy),       32'(1));
    step(1);
    chk("single_busy_j9", 32'(busy),       32'(0));
    step(5);

    // Burst while busy: FIFO fills to 4 and refuses the fifth byte for a while.
    push(8'hA0);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk("burst_full_count",  32'(fifo_count), 32'(4));
    chk("burst_full_sready", 32'(s_ready),    32'(0));
    push(8'h55);
    step(60);
    chk("burst_drained", 32'(fifo_count), 32'(0));

    // Output monitor: 0x00 -> 0x07 -> 0x07 -> 0x09.
    out_port = 8'h07;
    step(1);
    chk("mon_v1", 32'(m_valid), 32'(1));
    chk("mon_d1", 32'(m_data),  32'(8'h07));
    out_port = 8'h07;
    step(1);
    chk("mon_v2", 32'(m_valid), 32'(0));
    out_port = 8'h09;
    step(1);
    chk("mon_v3", 32'(m_valid), 32'(1));
    chk("mon_d3", 32'(m_data),  32'(8'h09));
    step(1);
    chk("mon_v4", 32'(m_valid), 32'(0));

    // Reset during ASSERT with two bytes queued.
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    wait_ready(1'b1);
    chk("rst_queued", 32'(fifo_count), 32'(2));
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_ready_in", 32'(ready_in),   32'(0));
    chk("rst_in_port",  32'(in_port),    32'(0));
    chk("rst_count",    32'(fifo_count), 32'(0));
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("rst_quiet", 32'(ready_in), 32'(0));
    end

    // CPU-like consumer: wait on synchronised ready_in, read in_port, write 2*x+1.
    cpu_bytes[0] = 8'h10;
    cpu_bytes[1] = 8'h20;
    cpu_bytes[2] = 8'h30;
    for (int i = 0; i < 3; i++) push(cpu_bytes[i]);
    for (int i = 0; i < 3; i++) begin
      wait_ready(1'b1);
      step(2);
      out_port = 8'(in_port * 2 + 1);
      exp_res  = 8'(cpu_bytes[i] * 2 + 1);
      step(1);
      chk("cpu_m_valid", 32'(m_valid), 32'(1));
      chk("cpu_m_data",  32'(m_data),  32'(exp_res));
      wait_ready(1'b0);
    end
    step(10);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 2) == 0);
      s_data  = 8'($urandom);
      if ($urandom_range(0, 1) == 1) out_port = 8'($urandom_range(0, 3));
      reset = ($urandom_range(0, 399) == 0);
      step(1);
    end
    reset   = 1'b0;
    s_valid = 1'b0;
    step(60);
    chk("final_drained", 32'(fifo_count), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
